// File: rtl/pc_fetch_ctrl.sv
// rtl/pc_fetch_ctrl.sv - program counter / fetch controller with stall, redirect flush and halt
// Optional macro PC_BOUND_CHECK_EN: halt with sticky bound_err instead of reaching the top address.

`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module pc_fetch_ctrl #(
    parameter int FLUSH_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  stall,
    input  logic                  branch_taken,
    input  logic [`MEM_SPACE-1:0] branch_target,
    input  logic                  halt_req,
    output logic [`MEM_SPACE-1:0] address,
    output logic                  PCctrl,
    output logic                  PChold,
    output logic                  halted,
    output logic                  bound_err,
    output logic [15:0]           fetch_count
);

    localparam int AW = `MEM_SPACE;
    localparam logic [AW-1:0] ADDR_MAX   = '1;
    localparam logic [2:0]    FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [15:0]     fcount_q, fcount_d;
    logic [AW-1:0]   addr_inc;
    logic            inc_hits_max;
    logic            tgt_hits_max;
    logic            pcctrl_c;
    logic            pchold_c;

    assign addr_inc = addr_q + 1'b1;

`ifdef PC_BOUND_CHECK_EN
    logic err_q, set_err;
    assign inc_hits_max = (addr_inc == ADDR_MAX);
    assign tgt_hits_max = (branch_target == ADDR_MAX);
    assign bound_err    = err_q;
`else
    assign inc_hits_max = 1'b0;
    assign tgt_hits_max = 1'b0;
    assign bound_err    = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        cnt_d    = cnt_q;
        fcount_d = fcount_q;
        pcctrl_c = 1'b0;
        pchold_c = 1'b0;
`ifdef PC_BOUND_CHECK_EN
        set_err  = 1'b0;
`endif
        case (state_q)
            RUN: begin
                if (halt_req) begin
                    pcctrl_c = 1'b1;
                    state_d  = HALT;
                end else if (branch_taken) begin
                    pcctrl_c = 1'b1;
                    if (tgt_hits_max) begin
                        state_d = HALT;
`ifdef PC_BOUND_CHECK_EN
                        set_err = 1'b1;
`endif
                    end else begin
                        addr_d  = branch_target;
                        cnt_d   = FLUSH_LOAD;
                        state_d = (FLUSH_CYCLES == 1) ? RUN : FLUSH;
                    end
                end else if (stall) begin
                    pchold_c = 1'b1;
                end else begin
                    fcount_d = (fcount_q == 16'hFFFF) ? fcount_q : fcount_q + 16'd1;
                    if (inc_hits_max) begin
                        state_d = HALT;
`ifdef PC_BOUND_CHECK_EN
                        set_err = 1'b1;
`endif
                    end else begin
                        addr_d = addr_inc;
                    end
                end
            end
            FLUSH: begin
                pcctrl_c = 1'b1;
                if (halt_req) begin
                    state_d = HALT;
                end else if (branch_taken) begin
                    // a second redirect restarts the bubble train from the new target
                    if (tgt_hits_max) begin
                        state_d = HALT;
`ifdef PC_BOUND_CHECK_EN
                        set_err = 1'b1;
`endif
                    end else begin
                        addr_d  = branch_target;
                        cnt_d   = FLUSH_LOAD;
                    end
                end else begin
                    cnt_d = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
                    if (cnt_q <= 3'd1) begin
                        state_d = RUN;
                    end
                end
            end
            HALT: begin
                pcctrl_c = 1'b1;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= RUN;
            addr_q   <= '0;
            cnt_q    <= 3'd0;
            fcount_q <= 16'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            cnt_q    <= cnt_d;
            fcount_q <= fcount_d;
        end
    end

`ifdef PC_BOUND_CHECK_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            err_q <= 1'b0;
        end else if (set_err) begin
            err_q <= 1'b1;
        end
    end
`endif

    // memory-control strobes are forced low while reset is asserted
    assign PCctrl      = rst & pcctrl_c;
    assign PChold      = rst & pchold_c;
    assign address     = addr_q;
    assign halted      = (state_q == HALT);
    assign fetch_count = fcount_q;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// tb/tb_pc_fetch_ctrl.sv - self-checking bench for pc_fetch_ctrl with a behavioural fetch model

`ifndef MEM_SPACE
`define MEM_SPACE 8
`endif

module tb_pc_fetch_ctrl;

    localparam int AW = `MEM_SPACE;
    localparam int FC = 2;
    localparam logic [AW-1:0] MAXA = '1;
`ifdef PC_BOUND_CHECK_EN
    localparam bit BOUND = 1'b1;
`else
    localparam bit BOUND = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          stall;
    logic          branch_taken;
    logic [AW-1:0] branch_target;
    logic          halt_req;
    logic [AW-1:0] address;
    logic          pcctrl;
    logic          pchold;
    logic          halted;
    logic          bound_err;
    logic [15:0]   fetch_count;

    int checks   = 0;
    int failures = 0;

    pc_fetch_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .halt_req     (halt_req),
        .address      (address),
        .PCctrl       (pcctrl),
        .PChold       (pchold),
        .halted       (halted),
        .bound_err    (bound_err),
        .fetch_count  (fetch_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: pc value, remaining flush bubbles, halt flag, fetch tally, error flag.
    bit            m_valid = 1'b0;
    logic [AW-1:0] m_addr;
    int            m_bub;
    bit            m_halt;
    logic [15:0]   m_cnt;
    bit            m_err;

    always @(posedge clk) begin
        if (!rst) begin
            m_valid <= 1'b1;
            m_addr  <= '0;
            m_bub   <= 0;
            m_halt  <= 1'b0;
            m_cnt   <= 16'd0;
            m_err   <= 1'b0;
        end else if (m_valid && !m_halt) begin
            if (halt_req) begin
                m_halt <= 1'b1;
            end else if (branch_taken) begin
                if (BOUND && branch_target == MAXA) begin
                    m_halt <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_addr <= branch_target;
                    m_bub  <= FC - 1;
                end
            end else if (m_bub > 0) begin
                m_bub <= m_bub - 1;
            end else if (!stall) begin
                if (m_cnt != 16'hFFFF) m_cnt <= m_cnt + 16'd1;
                if (BOUND && AW'(m_addr + 1) == MAXA) begin
                    m_halt <= 1'b1;
                    m_err  <= 1'b1;
                end else begin
                    m_addr <= AW'(m_addr + 1);
                end
            end
        end
    end

    always @(negedge clk) begin
        logic e_ctrl, e_hold;
        if (m_valid) begin
            if (!rst) begin
                e_ctrl = 1'b0;
                e_hold = 1'b0;
            end else if (m_halt || m_bub > 0) begin
                e_ctrl = 1'b1;
                e_hold = 1'b0;
            end else begin
                e_ctrl = halt_req | branch_taken;
                e_hold = stall & ~halt_req & ~branch_taken;
            end
            chk("mdl_address", 32'(address), 32'(m_addr));
            chk("mdl_PCctrl", 32'(pcctrl), 32'(e_ctrl));
            chk("mdl_PChold", 32'(pchold), 32'(e_hold));
            chk("mdl_halted", 32'(halted), 32'(m_halt));
            chk("mdl_bound_err", 32'(bound_err), 32'(m_err));
            chk("mdl_fetch_count", 32'(fetch_count), 32'(m_cnt));
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; branch_target = '0;
        step(2);
        chk("rst_address", 32'(address), 32'h0);
        chk("rst_fetch_count", 32'(fetch_count), 32'h0);
        branch_taken = 1'b1; stall = 1'b1; #1;
        chk("rst_pcctrl_low", 32'(pcctrl), 32'h0);
        chk("rst_pchold_low", 32'(pchold), 32'h0);
        branch_taken = 1'b0; stall = 1'b0;
        rst = 1'b1;

        step(5);
        chk("run5_address", 32'(address), 32'h5);
        chk("run5_count", 32'(fetch_count), 32'd5);
        step(1);

        stall = 1'b1; #1;
        chk("stall1_pchold", 32'(pchold), 32'h1);
        step(1);
        chk("stall2_address", 32'(address), 32'h6);
        chk("stall2_pchold", 32'(pchold), 32'h1);
        step(1);
        stall = 1'b0;
        chk("stall_count", 32'(fetch_count), 32'd6);
        step(1);
        chk("post_stall_address", 32'(address), 32'h7);

        step(2);
        chk("pre_branch_address", 32'(address), 32'h9);
        branch_taken = 1'b1; branch_target = 8'h40; #1;
        chk("branch_pcctrl", 32'(pcctrl), 32'h1);
        step(1);
        branch_taken = 1'b0; #1;
        chk("flush_address", 32'(address), 32'h40);
        chk("flush_pcctrl", 32'(pcctrl), 32'h1);
        step(1);
        chk("target_fetch_address", 32'(address), 32'h40);
        chk("target_fetch_pcctrl", 32'(pcctrl), 32'h0);
        step(1);
        chk("target_next_address", 32'(address), 32'h41);
        chk("branch_count", 32'(fetch_count), 32'd10);

        branch_taken = 1'b1; branch_target = 8'h20;
        step(1);
        branch_target = 8'h30; #1;
        chk("rebranch_pcctrl", 32'(pcctrl), 32'h1);
        step(1);
        branch_taken = 1'b0; #1;
        chk("rebranch_address", 32'(address), 32'h30);
        chk("rebranch_flush_pcctrl", 32'(pcctrl), 32'h1);
        step(1);
        chk("rebranch_run_pcctrl", 32'(pcctrl), 32'h0);
        step(1);
        chk("rebranch_next_address", 32'(address), 32'h31);

        branch_taken = 1'b1; branch_target = 8'h50; stall = 1'b1;
        step(1);
        branch_taken = 1'b0; #1;
        chk("flush_stall_pchold", 32'(pchold), 32'h0);
        step(1);
        chk("run_stall_pchold", 32'(pchold), 32'h1);
        stall = 1'b0;
        step(1);
        chk("after_flush_stall_address", 32'(address), 32'h51);

        halt_req = 1'b1; branch_taken = 1'b1; branch_target = 8'h77; stall = 1'b1;
        step(1);
        halt_req = 1'b0; stall = 1'b0; branch_target = 8'h10; #1;
        chk("halt_halted", 32'(halted), 32'h1);
        chk("halt_pcctrl", 32'(pcctrl), 32'h1);
        chk("halt_address", 32'(address), 32'h51);
        step(1);
        branch_taken = 1'b0;
        step(3);
        chk("halt_frozen_address", 32'(address), 32'h51);
        rst = 1'b0; #1;
        chk("halt_rst_pcctrl", 32'(pcctrl), 32'h0);
        step(1);
        rst = 1'b1;
        chk("halt_exit_address", 32'(address), 32'h0);
        chk("halt_exit_halted", 32'(halted), 32'h0);

        step(3);
        branch_taken = 1'b1; branch_target = 8'h60;
        step(1);
        branch_taken = 1'b0; rst = 1'b0;
        step(1);
        rst = 1'b1; #1;
        chk("flush_rst_pcctrl", 32'(pcctrl), 32'h0);
        step(1);
        chk("flush_rst_address", 32'(address), 32'h1);

        branch_taken = 1'b1; branch_target = 8'hFD;
        step(1);
        branch_taken = 1'b0;
        step(1);
        chk("edge_start_address", 32'(address), 32'hFD);
        step(1);
        chk("edge_fe_address", 32'(address), 32'hFE);
`ifdef PC_BOUND_CHECK_EN
        step(1);
        chk("bound_address", 32'(address), 32'hFE);
        chk("bound_halted", 32'(halted), 32'h1);
        chk("bound_err", 32'(bound_err), 32'h1);
        step(2);
        chk("bound_sticky", 32'(bound_err), 32'h1);
`else
        step(1);
        chk("wrap_ff_address", 32'(address), 32'hFF);
        step(1);
        chk("wrap_00_address", 32'(address), 32'h0);
        chk("wrap_bound_err", 32'(bound_err), 32'h0);
`endif
        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 The block SHALL have parameter FLUSH_CYCLES, default 2, giving the total NOP bubbles per redirect (legal range 1..7).
REQ-002 The block SHALL take address width `MEM_SPACE from define.v; no other width parameters.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-low reset; sampled on posedge clk only.
REQ-005 stall  input  1  hazard stall request from decode.
REQ-006 branch_taken  input  1  redirect request, single-cycle pulse.
REQ-007 branch_target  input  `MEM_SPACE  redirect destination address.
REQ-008 halt_req  input  1  stop fetching, single-cycle pulse.
REQ-009 address  output  `MEM_SPACE  program counter driven to instruction memory.
REQ-010 PCctrl  output  1  1 = instruction memory emits NOP this edge.
REQ-011 PChold  output  1  1 = instruction memory refetches address-1.
REQ-012 halted  output  1  1 while in HALT.
REQ-013 bound_err  output  1  sticky flag: address bound violation.
REQ-014 fetch_count  output  16  count of cycles in which a new instruction was fetched.

Function
REQ-015 The block SHALL implement states RUN, FLUSH, HALT, held in a registered state variable.
REQ-016 In RUN with no stall, redirect or halt, address SHALL increment by 1 per cycle, modulo 2^`MEM_SPACE (unless REQ-029 applies).
REQ-017 In RUN with stall=1 and branch_taken=0, address SHALL hold, and PChold SHALL be 1 combinationally in that cycle.
REQ-018 PChold SHALL be 0 in FLUSH and HALT regardless of stall.
REQ-019 In RUN, branch_taken=1 SHALL load address<=branch_target, load flush counter<=FLUSH_CYCLES-1, and move to FLUSH (to RUN if FLUSH_CYCLES=1).
REQ-020 PCctrl SHALL be 1 combinationally in the cycle branch_taken=1, so the wrong-path word is replaced by NOP.
REQ-021 In FLUSH, PCctrl SHALL be 1, address SHALL hold, and the counter SHALL decrement each cycle; leave for RUN in the cycle it reads 0.
REQ-022 Priority SHALL be halt_req > branch_taken > stall.
REQ-023 branch_taken in FLUSH SHALL reload address and counter (restart the flush); stall in FLUSH SHALL be ignored.
REQ-024 halt_req in any state SHALL enter HALT next cycle; in HALT, PCctrl=1, halted=1, address frozen, and only rst exits.
REQ-025 fetch_count SHALL increment in each RUN cycle with PCctrl=0 and stall=0, saturating at 16'hFFFF.
REQ-026 Memory latency SHALL be 1 cycle: the word at address appears at memory data_out after the next edge; the block adds no further latency.

Reset
REQ-027 With rst=0 at a posedge: address=0, state=RUN, flush counter=0, fetch_count=0, bound_err=0, halted=0.
REQ-028 During reset, PCctrl and PChold SHALL be 0; reset mid-FLUSH or mid-HALT SHALL abandon that state with no residual bubbles.

Configuration
REQ-029 With macro PC_BOUND_CHECK_EN defined, an increment or redirect that would reach address 2^`MEM_SPACE-1 SHALL instead enter HALT with bound_err=1 (sticky until reset), holding address.
REQ-030 Without PC_BOUND_CHECK_EN, address SHALL wrap from 2^`MEM_SPACE-1 to 0 and bound_err SHALL be tied to 0.

Verification (MEM_SPACE=8, FLUSH_CYCLES=2)
REQ-031 Reset, then 5 free-run cycles -> address 0,1,2,3,4,5; PCctrl=0; fetch_count=5.
REQ-032 At address=6, stall for 2 cycles -> address stays 6, PChold=1 for both cycles, fetch_count unchanged, then increments to 7.
REQ-033 At address=9, branch_taken with target=8'h40 -> PCctrl=1 that cycle and the next; address=8'h40 for 2 cycles, then 8'h41.
REQ-034 branch_taken with target=8'h20, then a second branch_taken with target=8'h30 one cycle later (in FLUSH) -> address=8'h30, PCctrl=1 for 2 cycles counted from the second pulse.
REQ-035 halt_req coincident with branch_taken and stall -> next cycle halted=1, PCctrl=1, address unchanged; rst=0 restores address=0, halted=0.
REQ-036 Run from address=8'hFD: with PC_BOUND_CHECK_EN -> HALT at 8'hFE, bound_err=1; without it -> 8'hFE, 8'hFF, 8'h00, bound_err=0.
